lcd_frame_timer: RTL and testbench



---
 rtl/gfx_timing_pkg.sv | 14 +
 rtl/wrap_counter.sv | 40 ++++
 rtl/lcd_frame_timer.sv | 148 ++++++++++++++
 tb/tb_lcd_frame_timer.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gfx_timing_pkg.sv
// Shared graphics timing constants and counter types.
// Defaults describe the GBA LCD: 240x160 visible, 308x228 total, 4 clocks per dot.
package gfx_timing_pkg;

    localparam int GBA_H_ACTIVE = 240;
    localparam int GBA_H_TOTAL  = 308;
    localparam int GBA_V_ACTIVE = 160;
    localparam int GBA_V_TOTAL  = 228;
    localparam int GBA_DOT_DIV  = 4;

    typedef logic [8:0] hcount_t;
    typedef logic [7:0] vcount_t;

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter 0..MAX with synchronous clear and a terminal-count flag.
// Clear has priority over the count enable.
module wrap_counter #(
    parameter int WIDTH = 8,
    parameter int MAX   = 255
) (
    input  logic             graphics_clock,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    output logic [WIDTH-1:0] Q,
    output logic             last
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    assign last = (q_q == MAX_V);
    assign Q    = q_q;

    always_comb begin
        q_d = q_q;
        if (clear) begin
            q_d = '0;
        end else if (en) begin
            q_d = last ? '0 : q_q + WIDTH'(1);
        end
    end

    always_ff @(posedge graphics_clock or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/lcd_frame_timer.sv
// LCD frame timing: dot prescaler, h/v counters, framebuffer write address,
// blanking/LYC status, one-cycle event pulses and the double-buffer swap.
module lcd_frame_timer
    import gfx_timing_pkg::*;
#(
    parameter int H_ACTIVE = GBA_H_ACTIVE,
    parameter int H_TOTAL  = GBA_H_TOTAL,
    parameter int V_ACTIVE = GBA_V_ACTIVE,
    parameter int V_TOTAL  = GBA_V_TOTAL,
    parameter int DOT_DIV  = GBA_DOT_DIV,
    parameter int ADDR_W   = 17,
    parameter int HC_W     = $clog2(H_TOTAL),
    parameter int VC_W     = $clog2(V_TOTAL)
) (
    input  logic              graphics_clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [VC_W-1:0]   vcount_target,
    output logic              dot_en,
    output logic [HC_W-1:0]   hcount,
    output logic [VC_W-1:0]   vcount,
    output logic              wen,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              hblank,
    output logic              vblank,
    output logic              vcount_match,
    output logic              irq_hblank,
    output logic              irq_vblank,
    output logic              irq_vcount,
    output logic              toggle,
    output logic              front_buf
);

    localparam int PRE_W = (DOT_DIV > 1) ? $clog2(DOT_DIV) : 1;

    localparam logic [HC_W-1:0] H_ACT      = HC_W'(H_ACTIVE);
    localparam logic [HC_W-1:0] H_ACT_M1   = HC_W'(H_ACTIVE - 1);
    localparam logic [VC_W-1:0] V_ACT      = VC_W'(V_ACTIVE);
    localparam logic [VC_W-1:0] V_ACT_M1   = VC_W'(V_ACTIVE - 1);
    localparam logic [VC_W-1:0] V_BLK_LAST = VC_W'(V_TOTAL - 2);

    if (H_ACTIVE >= H_TOTAL) begin : g_bad_h
        $error("lcd_frame_timer: H_ACTIVE must be less than H_TOTAL");
    end
    if (V_ACTIVE >= V_TOTAL - 1) begin : g_bad_v
        $error("lcd_frame_timer: V_ACTIVE must be less than V_TOTAL-1");
    end
    if (DOT_DIV < 1) begin : g_bad_div
        $error("lcd_frame_timer: DOT_DIV must be at least 1");
    end
    if (longint'(H_ACTIVE) * longint'(V_ACTIVE) >= (longint'(1) << ADDR_W)) begin : g_bad_addr
        $error("lcd_frame_timer: ADDR_W too narrow for H_ACTIVE*V_ACTIVE");
    end

    // Only the prescaler's terminal flag matters; its phase value is not consumed.
    logic [PRE_W-1:0] pre_phase_unused;
    logic             pre_last;
    logic             h_last;
    logic             v_last;
    logic             line_wrap;
    logic             frame_wrap;
    logic [VC_W-1:0]  v_next;

    logic [ADDR_W-1:0] fb_addr_q, fb_addr_d;
    logic              front_buf_q, front_buf_d;
    logic              irq_hblank_q, irq_hblank_d;
    logic              irq_vblank_q, irq_vblank_d;
    logic              irq_vcount_q, irq_vcount_d;
    logic              toggle_q, toggle_d;

    wrap_counter #(.WIDTH(PRE_W), .MAX(DOT_DIV - 1)) u_pre (
        .graphics_clock (graphics_clock),
        .reset          (reset),
        .en             (enable),
        .clear          (1'b0),
        .Q              (pre_phase_unused),
        .last           (pre_last)
    );

    wrap_counter #(.WIDTH(HC_W), .MAX(H_TOTAL - 1)) u_hcount (
        .graphics_clock (graphics_clock),
        .reset          (reset),
        .en             (dot_en),
        .clear          (1'b0),
        .Q              (hcount),
        .last           (h_last)
    );

    wrap_counter #(.WIDTH(VC_W), .MAX(V_TOTAL - 1)) u_vcount (
        .graphics_clock (graphics_clock),
        .reset          (reset),
        .en             (line_wrap),
        .clear          (1'b0),
        .Q              (vcount),
        .last           (v_last)
    );

    assign dot_en       = enable & pre_last;
    assign line_wrap    = dot_en & h_last;
    assign frame_wrap   = line_wrap & v_last;
    assign v_next       = v_last ? '0 : vcount + VC_W'(1);

    assign wen          = enable && (hcount < H_ACT) && (vcount < V_ACT);
    assign hblank       = (hcount >= H_ACT);
    assign vblank       = (vcount >= V_ACT) && (vcount <= V_BLK_LAST);
    assign vcount_match = (vcount == vcount_target);

    // Pulses are decoded one edge early so they line up with the new counter value.
    always_comb begin
        fb_addr_d = fb_addr_q;
        if (frame_wrap) begin
            fb_addr_d = '0;
        end else if (dot_en && wen) begin
            fb_addr_d = fb_addr_q + ADDR_W'(1);
        end
        front_buf_d  = front_buf_q ^ frame_wrap;
        irq_hblank_d = dot_en && (hcount == H_ACT_M1);
        irq_vblank_d = line_wrap && (vcount == V_ACT_M1);
        irq_vcount_d = line_wrap && (v_next == vcount_target);
        toggle_d     = frame_wrap;
    end

    always_ff @(posedge graphics_clock or posedge reset) begin
        if (reset) begin
            fb_addr_q    <= '0;
            front_buf_q  <= 1'b0;
            irq_hblank_q <= 1'b0;
            irq_vblank_q <= 1'b0;
            irq_vcount_q <= 1'b0;
            toggle_q     <= 1'b0;
        end else begin
            fb_addr_q    <= fb_addr_d;
            front_buf_q  <= front_buf_d;
            irq_hblank_q <= irq_hblank_d;
            irq_vblank_q <= irq_vblank_d;
            irq_vcount_q <= irq_vcount_d;
            toggle_q     <= toggle_d;
        end
    end

    assign fb_addr    = fb_addr_q;
    assign front_buf  = front_buf_q;
    assign irq_hblank = irq_hblank_q & enable;
    assign irq_vblank = irq_vblank_q & enable;
    assign irq_vcount = irq_vcount_q & enable;
    assign toggle     = toggle_q & enable;

endmodule

// File: tb/tb_lcd_frame_timer.sv
// Scoreboard bench for lcd_frame_timer: a small DOT_DIV=1 instance (A) and a
// DOT_DIV=3 instance (B); expected events are queued, a monitor pops and compares.
module tb_lcd_frame_timer;

    localparam int AHA = 3, AHT = 5, AVA = 2, AVT = 4, AD = 1, AAW = 4;
    localparam int BHA = 6, BHT = 9, BVA = 4, BVT = 7, BD = 3, BAW = 5;
    localparam int NEVER = 1 << 30;

    localparam logic [4:0] F_W  = 5'b10000;
    localparam logic [4:0] F_HB = 5'b01000;
    localparam logic [4:0] F_VB = 5'b00100;
    localparam logic [4:0] F_VC = 5'b00010;
    localparam logic [4:0] F_TG = 5'b00001;

    typedef struct {
        int         cyc;
        logic [4:0] fl;
        int         h;
        int         v;
        int         fb;
        logic       fbuf;
    } ev_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic           rst_a, en_a;
    logic [1:0]     tgt_a;
    logic           a_dot, a_wen, a_hb, a_vbk, a_match, a_ihb, a_ivb, a_ivc, a_tg, a_fbuf;
    logic [2:0]     a_h;
    logic [1:0]     a_v;
    logic [AAW-1:0] a_fb;

    logic           rst_b, en_b;
    logic [2:0]     tgt_b;
    logic           b_dot, b_wen, b_hb, b_vbk, b_match, b_ihb, b_ivb, b_ivc, b_tg, b_fbuf;
    logic [3:0]     b_h;
    logic [2:0]     b_v;
    logic [BAW-1:0] b_fb;

    lcd_frame_timer #(.H_ACTIVE(AHA), .H_TOTAL(AHT), .V_ACTIVE(AVA), .V_TOTAL(AVT),
                      .DOT_DIV(AD), .ADDR_W(AAW)) dut_a (
        .graphics_clock (clk),      .reset        (rst_a),   .enable     (en_a),
        .vcount_target  (tgt_a),    .dot_en       (a_dot),   .hcount     (a_h),
        .vcount         (a_v),      .wen          (a_wen),   .fb_addr    (a_fb),
        .hblank         (a_hb),     .vblank       (a_vbk),   .vcount_match (a_match),
        .irq_hblank     (a_ihb),    .irq_vblank   (a_ivb),   .irq_vcount (a_ivc),
        .toggle         (a_tg),     .front_buf    (a_fbuf)
    );

    lcd_frame_timer #(.H_ACTIVE(BHA), .H_TOTAL(BHT), .V_ACTIVE(BVA), .V_TOTAL(BVT),
                      .DOT_DIV(BD), .ADDR_W(BAW)) dut_b (
        .graphics_clock (clk),      .reset        (rst_b),   .enable     (en_b),
        .vcount_target  (tgt_b),    .dot_en       (b_dot),   .hcount     (b_h),
        .vcount         (b_v),      .wen          (b_wen),   .fb_addr    (b_fb),
        .hblank         (b_hb),     .vblank       (b_vbk),   .vcount_match (b_match),
        .irq_hblank     (b_ihb),    .irq_vblank   (b_ivb),   .irq_vcount (b_ivc),
        .toggle         (b_tg),     .front_buf    (b_fbuf)
    );

    int  checks = 0;
    int  errors = 0;
    ev_t qa[$];
    ev_t qb[$];

    // First frame of A after reset, target 0: {cycle, flags, h, v, fb_addr}
    int tab_a [12][5] = '{
        '{0, 16, 0, 0, 0}, '{1, 16, 1, 0, 1}, '{2, 16, 2, 0, 2}, '{3, 8, 3, 0, 3},
        '{5, 16, 0, 1, 3}, '{6, 16, 1, 1, 4}, '{7, 16, 2, 1, 5}, '{8, 8, 3, 1, 6},
        '{10, 4, 0, 2, 6}, '{13, 8, 3, 2, 6}, '{18, 8, 3, 3, 6}, '{20, 19, 0, 0, 0}
    };

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic cmp_ev(input string nm, input ev_t a, input ev_t e);
        checks++;
        if (a.cyc != e.cyc || a.fl != e.fl || a.h != e.h || a.v != e.v ||
            a.fb != e.fb || a.fbuf != e.fbuf) begin
            errors++;
            $display("FAIL %s_event: got cyc=%0d fl=%b h=%0d v=%0d fb=%0d fbuf=%0d expected cyc=%0d fl=%b h=%0d v=%0d fb=%0d fbuf=%0d",
                     nm, a.cyc, a.fl, a.h, a.v, a.fb, a.fbuf, e.cyc, e.fl, e.h, e.v, e.fb, e.fbuf);
        end
    endtask

    task automatic push(input int id, input int c, input logic [4:0] f, input int h,
                        input int v, input int fb, input logic fbuf);
        ev_t e;
        e.cyc = c; e.fl = f; e.h = h; e.v = v; e.fb = fb; e.fbuf = fbuf;
        if (id == 0) qa.push_back(e);
        else         qb.push_back(e);
    endtask

    // Closed-form timing model over enabled-cycle index e; cycles from fe on are
    // shifted by fl to account for a freeze of fl clocks.
    task automatic gen(input int id, input int base, input int lo, input int hi,
                       input int tgt, input int fe, input int fl);
        int ha, ht, va, vt, d;
        if (id == 0) begin ha = AHA; ht = AHT; va = AVA; vt = AVT; d = AD; end
        else         begin ha = BHA; ht = BHT; va = BVA; vt = BVT; d = BD; end
        for (int e = lo; e < hi; e++) begin
            int pre, dn, h, ln, v, fb;
            logic [4:0] f;
            logic fbuf;
            pre  = e % d;
            dn   = e / d;
            h    = dn % ht;
            ln   = dn / ht;
            v    = ln % vt;
            fbuf = ((ln / vt) % 2) != 0;
            f    = '0;
            if (pre == d - 1 && h < ha && v < va) f |= F_W;
            if (e > 0 && pre == 0) begin
                if (h == ha) f |= F_HB;
                if (h == 0 && v == va) f |= F_VB;
                if (h == 0 && v == tgt) f |= F_VC;
                if (h == 0 && v == 0) f |= F_TG;
            end
            fb = (v < va) ? v * ha + ((h < ha) ? h : ha) : ha * va;
            if (f != '0) push(id, base + e + ((e >= fe) ? fl : 0), f, h, v, fb, fbuf);
        end
    endtask

    task automatic go_to(input int c);
        while (cyc < c) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst_a && ((a_wen && a_dot) || a_ihb || a_ivb || a_ivc || a_tg)) begin
                ev_t act;
                act.cyc = cyc; act.fl = {a_wen && a_dot, a_ihb, a_ivb, a_ivc, a_tg};
                act.h = int'(a_h); act.v = int'(a_v); act.fb = int'(a_fb); act.fbuf = a_fbuf;
                if (qa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL a_extra_event: got cyc=%0d fl=%b expected none", act.cyc, act.fl);
                end else begin
                    cmp_ev("a", act, qa.pop_front());
                end
            end
            if (!rst_b && ((b_wen && b_dot) || b_ihb || b_ivb || b_ivc || b_tg)) begin
                ev_t act;
                act.cyc = cyc; act.fl = {b_wen && b_dot, b_ihb, b_ivb, b_ivc, b_tg};
                act.h = int'(b_h); act.v = int'(b_v); act.fb = int'(b_fb); act.fbuf = b_fbuf;
                if (qb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b_extra_event: got cyc=%0d fl=%b expected none", act.cyc, act.fl);
                end else begin
                    cmp_ev("b", act, qb.pop_front());
                end
            end
        end
    endtask

    task automatic rst_chk_a(input string p);
        chk({p, "_hcount"}, int'(a_h), 0);
        chk({p, "_vcount"}, int'(a_v), 0);
        chk({p, "_fb_addr"}, int'(a_fb), 0);
        chk({p, "_front_buf"}, int'(a_fbuf), 0);
        chk({p, "_blank"}, int'({a_hb, a_vbk}), 0);
        chk({p, "_pulses"}, int'({a_ihb, a_ivb, a_ivc, a_tg}), 0);
        chk({p, "_wen"}, int'(a_wen), 1);
    endtask

    task automatic rst_chk_b(input string p);
        chk({p, "_hcount"}, int'(b_h), 0);
        chk({p, "_vcount"}, int'(b_v), 0);
        chk({p, "_fb_addr"}, int'(b_fb), 0);
        chk({p, "_front_buf"}, int'(b_fbuf), 0);
        chk({p, "_blank"}, int'({b_hb, b_vbk}), 0);
        chk({p, "_pulses"}, int'({b_ihb, b_ivb, b_ivc, b_tg}), 0);
        chk({p, "_wen"}, int'(b_wen), 1);
    endtask

    initial begin
        int ra, ra2, rb;
        rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b1; en_b = 1'b1;
        tgt_a = 2'd0; tgt_b = 3'd2;
        fork
            monitor();
        join_none

        repeat (3) @(posedge clk);
        #1;
        rst_chk_a("a_rst");
        rst_chk_b("b_rst");

        // Instance A: three frames, a mid-line target change, a freeze, then async reset.
        ra = cyc;
        rst_a = 1'b0;
        for (int i = 0; i < 12; i++)
            push(0, ra + tab_a[i][0], 5'(tab_a[i][1]), tab_a[i][2], tab_a[i][3],
                 tab_a[i][4], tab_a[i][0] == 20);
        gen(0, ra, 21, 66, 0, NEVER, 0);
        gen(0, ra, 66, 102, 1, NEVER, 0);
        gen(0, ra, 102, 151, 1, 102, 7);

        go_to(ra + 3);
        chk("a_hblank_h3", int'(a_hb), 1);
        go_to(ra + 10);
        chk("a_vblank_v2", int'(a_vbk), 1);
        go_to(ra + 15);
        chk("a_vcount_last_line", int'(a_v), 3);
        chk("a_vblank_last_line", int'(a_vbk), 0);

        go_to(ra + 66);
        chk("a_match_before", int'(a_match), 0);
        tgt_a = 2'd1;
        #1;
        chk("a_match_midline", int'(a_match), 1);

        go_to(ra + 102);
        en_a = 1'b0;
        go_to(ra + 105);
        chk("a_freeze_hcount", int'(a_h), 2);
        chk("a_freeze_vcount", int'(a_v), 0);
        chk("a_freeze_fb_addr", int'(a_fb), 2);
        chk("a_freeze_dot_en", int'(a_dot), 0);
        chk("a_freeze_wen", int'(a_wen), 0);
        go_to(ra + 109);
        en_a = 1'b1;

        go_to(ra + 158);
        chk("a_vblank_pre_reset", int'(a_vbk), 1);
        #2;
        rst_a = 1'b1;
        #1;
        rst_chk_a("a_async_rst");
        chk("a_drain_1", qa.size(), 0);

        go_to(cyc + 2);
        ra2 = cyc;
        rst_a = 1'b0;
        gen(0, ra2, 0, 47, 1, NEVER, 0);
        go_to(ra2 + 47);
        rst_a = 1'b1;
        chk("a_drain_2", qa.size(), 0);

        // Instance B: prescaled dot rate, freeze landing mid-prescale.
        rb = cyc;
        rst_b = 1'b0;
        gen(1, rb, 0, 420, 2, 94, 5);
        chk("b_dot_en_c0", int'(b_dot), 0);
        go_to(rb + 2);
        chk("b_dot_en_c2", int'(b_dot), 1);
        chk("b_hcount_c2", int'(b_h), 0);
        go_to(rb + 3);
        chk("b_hcount_c3", int'(b_h), 1);
        go_to(rb + 94);
        en_b = 1'b0;
        go_to(rb + 96);
        chk("b_freeze_hcount", int'(b_h), 4);
        chk("b_freeze_vcount", int'(b_v), 3);
        chk("b_freeze_fb_addr", int'(b_fb), 22);
        chk("b_freeze_dot_en", int'(b_dot), 0);
        chk("b_freeze_wen", int'(b_wen), 0);
        go_to(rb + 99);
        en_b = 1'b1;
        go_to(rb + 425);
        rst_b = 1'b1;
        chk("b_drain", qb.size(), 0);

        #20;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
